alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Registered, handshaked successor of the combinational ALU: same alu_ctrl opcode map, plus a registered result and ZNCV flags.
//   MUL uses an iterative shift-add engine and DIV a restoring divider, both multi-cycle, removing the long combinational paths.
//   Sits in the EX stage; the control unit issues with start and stalls while busy.
// PARAMETERS
//   N        32   operand/result width (>=4)
//   CNT_W    $clog2(N)+1   iteration counter width (derived, not overridden)
// PORTS
//   clk         in   1     system clock, rising edge
//   rst         in   1     synchronous reset, active-high
//   start       in   1     issue request; accepted at an edge where start=1 and busy=0
//   alu_ctrl    in   5     opcode, sampled at the accepting edge
//   src_A       in   N     operand A, sampled at the accepting edge
//   src_B       in   N     operand B, sampled at the accepting edge
//   busy        out  1     multi-cycle op in flight; start ignored
//   done        out  1     one-cycle pulse: alu_result/alu_flags valid for the op just finished
//   alu_result  out  N     registered result, held until next done
//   alu_flags   out  4     [3]=Z [2]=N [1]=C [0]=V, held until next flag-updating done
// BEHAVIOUR
//   Reset (rst=1 at an edge): busy=0, done=0, alu_result=0, alu_flags=0, FSM->IDLE, in-flight op aborted, no done.
//   FSM: IDLE -> ITER (MUL/DIV accepted) -> IDLE after N iterations; all other opcodes complete from IDLE.
//   Single-cycle ops: accepted at edge E0, result/flags written at E0, done=1 during the following cycle (latency 1).
//   MUL/DIV: operands latched at E0, busy=1 from E0; one iteration per edge E1..EN; result written at EN,
//     busy=0 and done=1 in the cycle after EN (latency N). New start is legal in the done cycle (back-to-back).
//   start while busy=1: ignored, no queueing. start=0: done returns to 0 next cycle, outputs hold.
//   Opcodes (unsigned unless stated; results truncated to N bits):
//     1 ADD A+B | 2 SUB A-B | 3 MUL low N bits of A*B | 4 MOVE A | 5 DIV floor(A/B)
//     9 AND | 10 OR | 11 XOR | 12 NOT ~A | 17 LDR A+B | 19 STR A+B | 25..30 jumps: pass A
//     other: result 0, flags Z=1 N=C=V=0, latency 1
//   Flags: Z=(result==0), N=result[N-1] for all flag-updating ops.
//     ADD: C=carry-out, V=signed overflow. SUB: C=1 iff A>=B unsigned (no borrow), V=signed overflow.
//     MUL/MOVE/logic: C=0, V=0. DIV: C=0, V=1 iff B==0.
//     LDR/STR/jumps (17,19,25..30): alu_flags unchanged; result and done still produced.
//   DIV by zero: still takes N cycles; result all-ones, V=1.
//   rst during ITER: aborts; no done pulse; next start accepted normally.
// TESTING (N=32)
//   ADD A=0x7FFFFFFF B=1 -> done 1 cycle later, result 0x80000000, flags 4'b0101.
//   SUB A=5 B=5 -> result 0, flags 4'b1010; SUB A=3 B=5 -> 0xFFFFFFFE, flags 4'b0100.
//   MUL A=7 B=6 -> busy 32 cycles, done at 32, result 42, flags 0; MUL 0x10000*0x10000 -> 0, flags 4'b1000.
//   DIV A=100 B=7 -> 14 after 32 cycles; DIV A=5 B=0 -> 0xFFFFFFFF, flags 4'b0101.
//   DIV issued, start+ADD pulsed at iteration 5 -> ignored; rst at iteration 10 -> busy=0, no done, outputs 0.
//   LDR A=0x100 B=4 after SUB 5-5 -> result 0x104, flags stay 4'b1010; start AND on MUL done cycle -> accepted.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU.
// Single-cycle opcodes complete from IDLE with a one-cycle done pulse.
// MUL (shift-add) and DIV (restoring) each run N iterations in ITER.
module alu_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   alu_ctrl,
  input  logic [N-1:0] src_A,
  input  logic [N-1:0] src_B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] alu_result,
  output logic [3:0]   alu_flags
);

  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_MUL  = 5'd3;
  localparam logic [4:0] OP_MOVE = 5'd4;
  localparam logic [4:0] OP_DIV  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_XOR  = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;
  localparam logic [4:0] OP_LDR  = 5'd17;
  localparam logic [4:0] OP_STR  = 5'd19;

  typedef enum logic {IDLE, ITER} state_t;

  state_t           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // MUL: opa = shifted multiplicand, opb = shifted multiplier, acc = product.
  // DIV: opa = dividend shifting out / quotient shifting in, opb = divisor,
  //      acc = partial remainder (always < divisor, so N bits suffice).
  logic [N-1:0]     opa_q, opa_d;
  logic [N-1:0]     opb_q, opb_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             done_q, done_d;
  logic [N-1:0]     result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  // Single-cycle datapath terms.
  logic [N:0]       add_ext;
  logic [N-1:0]     add_res;
  logic [N-1:0]     sub_res;
  logic             add_v;
  logic             sub_v;

  // Iteration datapath terms.
  logic [N-1:0]     mul_acc_next;
  logic [N:0]       div_shifted;
  logic             div_ge;
  logic [N-1:0]     div_rem_next;
  logic [N-1:0]     div_quo_next;
  logic [N-1:0]     iter_res;

  assign add_ext = {1'b0, src_A} + {1'b0, src_B};
  assign add_res = add_ext[N-1:0];
  assign sub_res = src_A - src_B;
  assign add_v   = (src_A[N-1] == src_B[N-1]) && (add_res[N-1] != src_A[N-1]);
  assign sub_v   = (src_A[N-1] != src_B[N-1]) && (sub_res[N-1] != src_A[N-1]);

  assign mul_acc_next = acc_q + (opb_q[0] ? opa_q : '0);
  assign div_shifted  = {acc_q, opa_q[N-1]};
  assign div_ge       = (div_shifted >= {1'b0, opb_q});
  // The true difference is below the divisor, so modular N-bit math is exact.
  assign div_rem_next = div_ge ? (div_shifted[N-1:0] - opb_q) : div_shifted[N-1:0];
  assign div_quo_next = {opa_q[N-2:0], div_ge};
  assign iter_res     = is_div_q ? div_quo_next : mul_acc_next;

  assign busy       = (state_q == ITER);
  assign done       = done_q;
  assign alu_result = result_q;
  assign alu_flags  = flags_q;

  // Next-state, iteration step and result/flag selection.
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (alu_ctrl)
            OP_MUL, OP_DIV: begin
              state_d  = ITER;
              is_div_d = (alu_ctrl == OP_DIV);
              cnt_d    = '0;
              opa_d    = src_A;
              opb_d    = src_B;
              acc_d    = '0;
            end
            OP_ADD: begin
              done_d   = 1'b1;
              result_d = add_res;
              flags_d  = {add_res == '0, add_res[N-1], add_ext[N], add_v};
            end
            OP_SUB: begin
              done_d   = 1'b1;
              result_d = sub_res;
              flags_d  = {sub_res == '0, sub_res[N-1], src_A >= src_B, sub_v};
            end
            OP_MOVE: begin
              done_d   = 1'b1;
              result_d = src_A;
              flags_d  = {src_A == '0, src_A[N-1], 2'b00};
            end
            OP_AND: begin
              done_d   = 1'b1;
              result_d = src_A & src_B;
              flags_d  = {(src_A & src_B) == '0, src_A[N-1] & src_B[N-1], 2'b00};
            end
            OP_OR: begin
              done_d   = 1'b1;
              result_d = src_A | src_B;
              flags_d  = {(src_A | src_B) == '0, src_A[N-1] | src_B[N-1], 2'b00};
            end
            OP_XOR: begin
              done_d   = 1'b1;
              result_d = src_A ^ src_B;
              flags_d  = {(src_A ^ src_B) == '0, src_A[N-1] ^ src_B[N-1], 2'b00};
            end
            OP_NOT: begin
              done_d   = 1'b1;
              result_d = ~src_A;
              flags_d  = {src_A == '1, ~src_A[N-1], 2'b00};
            end
            // Address and jump-target ops leave the flags untouched.
            OP_LDR, OP_STR: begin
              done_d   = 1'b1;
              result_d = add_res;
            end
            5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30: begin
              done_d   = 1'b1;
              result_d = src_A;
            end
            default: begin
              done_d   = 1'b1;
              result_d = '0;
              flags_d  = 4'b1000;
            end
          endcase
        end
      end

      ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_d = div_rem_next;
          opa_d = div_quo_next;
        end else begin
          acc_d = mul_acc_next;
          opa_d = {opa_q[N-2:0], 1'b0};
          opb_d = {1'b0, opb_q[N-1:1]};
        end
        if (cnt_q == LAST_ITER) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          result_d = iter_res;
          // A zero divisor is reported through V; the quotient is all-ones.
          flags_d  = {iter_res == '0, iter_res[N-1], 1'b0,
                      is_div_q && (opb_q == '0)};
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq (N=32) with hand-computed values.
module tb_alu_seq;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   alu_ctrl = '0;
  logic [N-1:0] src_A = '0;
  logic [N-1:0] src_B = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .alu_ctrl   (alu_ctrl),
    .src_A      (src_A),
    .src_B      (src_B),
    .busy       (busy),
    .done       (done),
    .alu_result (alu_result),
    .alu_flags  (alu_flags)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; samples and drives happen 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one op for a single edge, then drop start.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    alu_ctrl = op;
    src_A    = a;
    src_B    = b;
    tick();
    start    = 1'b0;
  endtask

  // Single-cycle op: done must be high in the cycle right after acceptance.
  task automatic single(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef);
    issue(op, a, b);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_res"}, alu_result, er);
    check({tag, "_flg"}, 32'(alu_flags), 32'(ef));
  endtask

  // Multi-cycle op: busy through 31 more edges, done exactly after the 32nd.
  task automatic multi(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef);
    issue(op, a, b);
    check({tag, "_busy0"}, {30'd0, busy, done}, 32'd2);
    repeat (N - 1) tick();
    check({tag, "_busyN"}, {30'd0, busy, done}, 32'd2);
    tick();
    check({tag, "_done"}, {30'd0, busy, done}, 32'd1);
    check({tag, "_res"}, alu_result, er);
    check({tag, "_flg"}, 32'(alu_flags), 32'(ef));
  endtask

  initial begin
    logic saw_done;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", alu_result, 32'd0);
    check("rst_flg", 32'(alu_flags), 32'd0);

    // Single-cycle ops
    single("add_ovf", 5'd1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0101);
    tick();
    check("idle_done", 32'(done), 32'd0);
    check("idle_hold", alu_result, 32'h8000_0000);
    single("add_carry", 5'd1, 32'hFFFF_FFFF, 32'd1, 32'h0, 4'b1010);
    single("sub_eq", 5'd2, 32'd5, 32'd5, 32'h0, 4'b1010);
    single("ldr", 5'd17, 32'h100, 32'd4, 32'h104, 4'b1010);
    single("sub_lt", 5'd2, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0100);
    single("xor", 5'd11, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 4'b0000);
    single("not", 5'd12, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'b0100);
    single("move", 5'd4, 32'h8000_0001, 32'h0, 32'h8000_0001, 4'b0100);
    single("bad_op", 5'd7, 32'd5, 32'd9, 32'h0, 4'b1000);
    single("jump", 5'd25, 32'h1234, 32'd0, 32'h1234, 4'b1000);
    single("str", 5'd19, 32'h200, 32'h8, 32'h208, 4'b1000);

    // Multi-cycle ops, plus back-to-back AND in the MUL done cycle
    multi("mul_7x6", 5'd3, 32'd7, 32'd6, 32'd42, 4'b0000);
    single("and_b2b", 5'd9, 32'h0000_00FF, 32'h0000_000F, 32'h0000_000F, 4'b0000);
    multi("mul_wrap", 5'd3, 32'h0001_0000, 32'h0001_0000, 32'h0, 4'b1000);
    multi("mul_big", 5'd3, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 4'b0100);
    multi("div_100_7", 5'd5, 32'd100, 32'd7, 32'd14, 4'b0000);
    multi("div_by0", 5'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 4'b0101);

    // DIV with ignored start at iteration 5 and reset at iteration 10
    issue(5'd5, 32'd1000, 32'd3);
    repeat (4) tick();
    issue(5'd1, 32'd1, 32'd1);
    check("ign_busy", {30'd0, busy, done}, 32'd2);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {30'd0, busy, done}, 32'd0);
    check("abort_res", alu_result, 32'h0);
    check("abort_flg", 32'(alu_flags), 32'h0);
    saw_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_quiet", 32'(saw_done), 32'd0);
    single("post_abort", 5'd1, 32'd2, 32'd3, 32'd5, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
